d_cache_dm: RTL and testbench
=============================

Name: d_cache_dm

Overview:
Parametrised direct-mapped, write-back, write-allocate data cache between the core load/store stage and the word-wide data memory port. Replaces the fixed-range, tagless data store with real tags, valid and dirty bits, a miss-handling FSM with burst writeback and refill, and a clearable segmentation fault. A single outstanding request is allowed; the core stalls on `ready` low.

Parameters:
- ADDR_W, 20, byte address width.
- DATA_W, 32, word width. Fixed at 32 for this generation.
- LINE_WORDS, 8, words per line (32 B). Power of 2, ≥2.
- NUM_LINES, 8, number of lines. Power of 2. Default capacity is 256 B.
- SEG_LO, 20'h10200, lowest legal byte address.
- SEG_HI, 20'h103FF, highest legal byte address.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- addr_in  in  ADDR_W  request byte address.
- wr_data  in  DATA_W  store data.
- wr_en  in  1  store request.
- rd_en  in  1  load request.
- seg_clr  in  1  clears the sticky segmentation fault.
- ready  out  1  high only in IDLE; a request is accepted when ready is high.
- ack  out  1  one-cycle pulse when a request completes.
- rd_data  out  DATA_W  load result, valid while ack is high.
- miss  out  1  high while a miss is being serviced.
- d_cache_seg_fault  out  1  sticky fault flag.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  DATA_W  writeback data.
- mem_rdata  in  DATA_W  refill data, valid while mem_ack is high.
- mem_ack  in  1  beat complete.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset clears every valid bit, every dirty bit and the FSM (to IDLE).
  - Reset values: ack, miss, mem_req, mem_we, d_cache_seg_fault = 0; rd_data = 0; mem_addr = 0; mem_wdata = 0.
- Address split: offset = addr[1:0] (must be 0); word = next log2(LINE_WORDS) bits; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Accept:
  - At cycle T, ready && (rd_en || wr_en) registers addr, data and op.
  - If rd_en and wr_en are both high, the write wins.
- Fault:
  - A fault is an address outside [SEG_LO, SEG_HI] inclusive, or addr[1:0] != 0.
  - On a fault: no array or memory activity; ack pulses at T+1 with rd_data = 0; d_cache_seg_fault sets at T+1.
  - The flag holds until seg_clr is high at a clock edge. If set and clear occur in the same cycle, set wins.
- States: IDLE → LOOKUP → (HIT: IDLE) | (dirty victim: WB) | (clean victim: FILL); WB → FILL; FILL → DONE → IDLE.
- Hit (valid && tag match, evaluated at T+1):
  - Load: rd_data = word, ack at T+1.
  - Store: word written, dirty set, ack at T+1.
  - ready returns high at T+2.
- Miss:
  - miss goes high from T+1 until the ack cycle.
  - WB: LINE_WORDS write beats, word 0 first, mem_addr = {victim tag, index, word, 2'b00}.
  - FILL: LINE_WORDS read beats of the requested line, word 0 first. The line is written into the array as beats arrive. After the last beat the tag is written and valid set.
  - DONE: load returns the requested word; store merges its data and sets dirty. ack pulses and miss drops in this cycle.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata hold stable until the cycle mem_ack is high.
  - mem_req deasserts in the cycle after the final ack and may remain high across consecutive beats.
  - mem_ack is ignored when mem_req is low.
- Input sampling: inputs other than seg_clr are ignored while ready is low.
- Reset mid-operation: the FSM aborts to IDLE and dirty data is lost. This is acceptable; the memory controller reset is tied to the same rst_n.
- Storage: data array NUM_LINES×LINE_WORDS words, synchronous write. Tag, valid and dirty are held in flops.

Decomposition:
- Package d_cache_pkg:
  - state enum (IDLE, LOOKUP, WB, FILL, DONE);
  - derived localparam widths (WORD_BITS, IDX_BITS, TAG_BITS);
  - index/tag/word extraction functions.
- Sub-module dc_line_store: data array with one combinational read port and one write port, parametrised by NUM_LINES and LINE_WORDS.
- FSM, tags and fault logic live in d_cache_dm.

Test Plan:
- Cold read 0x10204 with memory pre-filled so word n of the line at 0x10200 = 0xA0+n:
  - miss high from T+1; 8 read beats 0x10200..0x1021C; no WB; ack with rd_data = 0xA1;
  - re-read → hit, ack at T+1, no mem_req.
- Store 0x10208 = 0xDEADBEEF (line resident), then read 0x10208 → 0xDEADBEEF with no memory traffic.
- Dirty eviction: dirty line at 0x10200, then read 0x10300 (same index):
  - 8 write beats at 0x10200..0x1021C carrying the merged data;
  - then 8 read beats at 0x10300..;
  - correct ack.
- Fault: read 0x10400 → ack at T+1, rd_data 0, seg_fault = 1 and sticky; also 0x10202 (misaligned) → fault. seg_clr → 0; a simultaneous new fault keeps it at 1.
- mem_ack stalls of 0–5 random cycles per beat: mem_req/mem_addr remain stable and results are identical.
- rst_n pulled low mid-FILL: all outputs go to 0 immediately; a subsequent read of the same address misses again.

Source files
------------

// File: rtl/d_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
package d_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    DONE
  } state_t;

  localparam int DEF_ADDR_W     = 20;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_NUM_LINES  = 8;
  localparam int WORD_BITS      = $clog2(DEF_LINE_WORDS);
  localparam int IDX_BITS       = $clog2(DEF_NUM_LINES);
  localparam int TAG_BITS       = DEF_ADDR_W - 2 - WORD_BITS - IDX_BITS;

  // Byte address layout: {tag, index, word, 2'b00}
  function automatic logic [31:0] addr_word(input logic [31:0] a, input int wbits);
    return (a >> 2) & ((32'd1 << wbits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int wbits,
                                             input int ibits);
    return (a >> (2 + wbits)) & ((32'd1 << ibits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int wbits,
                                           input int ibits);
    return a >> (2 + wbits + ibits);
  endfunction

endpackage

// File: rtl/dc_line_store.sv
// Cache data array addressed as {line index, word}: one synchronous write
// port and one combinational read port.
module dc_line_store #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int NUM_LINES  = 8,
  localparam int AW        = $clog2(NUM_LINES * LINE_WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_LINES*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/d_cache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with burst
// writeback/refill over a word-wide memory port and a sticky segment fault.
module d_cache_dm
  import d_cache_pkg::*;
#(
  parameter int              ADDR_W     = DEF_ADDR_W,
  parameter int              DATA_W     = 32,
  parameter int              LINE_WORDS = DEF_LINE_WORDS,
  parameter int              NUM_LINES  = DEF_NUM_LINES,
  parameter logic [ADDR_W-1:0] SEG_LO   = 20'h10200,
  parameter logic [ADDR_W-1:0] SEG_HI   = 20'h103FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              seg_clr,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              miss,
  output logic              d_cache_seg_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int C_WB = $clog2(LINE_WORDS);
  localparam int C_IB = $clog2(NUM_LINES);
  localparam int C_TB = ADDR_W - 2 - C_WB - C_IB;
  localparam int C_AW = C_IB + C_WB;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_wr;
  logic                r_fault;
  logic                r_seg_fault;
  logic [C_WB-1:0]     r_beat;
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [C_TB-1:0]     r_tag [NUM_LINES];

  logic [C_WB-1:0]     w_word;
  logic [C_IB-1:0]     w_idx;
  logic [C_TB-1:0]     w_req_tag;
  logic                w_accept;
  logic                w_fault_in;
  logic                w_hit;
  logic                w_last;
  logic                w_fill_last;
  logic                w_lookup_ok;

  logic                w_arr_we;
  logic [C_AW-1:0]     w_arr_waddr;
  logic [DATA_W-1:0]   w_arr_wdata;
  logic [C_AW-1:0]     w_arr_raddr;
  logic [DATA_W-1:0]   w_arr_rdata;

  assign w_word    = C_WB'(addr_word(32'(r_addr), C_WB));
  assign w_idx     = C_IB'(addr_index(32'(r_addr), C_WB, C_IB));
  assign w_req_tag = C_TB'(addr_tag(32'(r_addr), C_WB, C_IB));

  assign w_accept    = (r_state == IDLE) && (rd_en || wr_en);
  assign w_fault_in  = (addr_in < SEG_LO) || (addr_in > SEG_HI) || (addr_in[1:0] != 2'b00);
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_req_tag);
  assign w_last      = (r_beat == C_WB'(LINE_WORDS - 1));
  assign w_fill_last = (r_state == FILL) && mem_ack && w_last;
  assign w_lookup_ok = (r_state == LOOKUP) && !r_fault;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = LOOKUP;
      LOOKUP: begin
        if (r_fault || w_hit)                      w_state_next = IDLE;
        else if (r_valid[w_idx] && r_dirty[w_idx]) w_state_next = WB;
        else                                       w_state_next = FILL;
      end
      WB:      if (mem_ack && w_last) w_state_next = FILL;
      FILL:    if (w_fill_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_wr     <= 1'b0;
      r_fault     <= 1'b0;
      r_beat      <= '0;
      r_seg_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= addr_in;
        r_wdata <= wr_data;
        r_is_wr <= wr_en;
        r_fault <= w_fault_in;
        r_beat  <= '0;
      end else if ((r_state == WB || r_state == FILL) && mem_ack) begin
        r_beat <= r_beat + C_WB'(1);
      end
      // A new fault beats a simultaneous clear
      if (w_accept && w_fault_in) r_seg_fault <= 1'b1;
      else if (seg_clr)           r_seg_fault <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_lookup_ok && w_hit && r_is_wr) r_dirty[w_idx] <= 1'b1;
      // The line is about to be overwritten by the refill
      if (w_lookup_ok && !w_hit)           r_valid[w_idx] <= 1'b0;
      if (w_fill_last) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (r_state == DONE && r_is_wr)      r_dirty[w_idx] <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_tag
    always_ff @(posedge clk) begin
      if (w_fill_last && (w_idx == C_IB'(gi))) begin
        r_tag[gi] <= w_req_tag;
      end
    end
  end

  always_comb begin
    w_arr_we    = 1'b0;
    w_arr_waddr = {w_idx, w_word};
    w_arr_wdata = r_wdata;
    if (r_state == FILL && mem_ack) begin
      w_arr_we    = 1'b1;
      w_arr_waddr = {w_idx, r_beat};
      w_arr_wdata = mem_rdata;
    end else if ((w_lookup_ok && w_hit && r_is_wr) || (r_state == DONE && r_is_wr)) begin
      w_arr_we = 1'b1;
    end
  end

  assign w_arr_raddr = (r_state == WB) ? {w_idx, r_beat} : {w_idx, w_word};

  dc_line_store #(
    .DATA_W    (DATA_W),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES)
  ) u_store (
    .clk    (clk),
    .i_we   (w_arr_we),
    .i_waddr(w_arr_waddr),
    .i_wdata(w_arr_wdata),
    .i_raddr(w_arr_raddr),
    .o_rdata(w_arr_rdata)
  );

  assign ready             = (r_state == IDLE);
  assign ack               = ((r_state == LOOKUP) && (r_fault || w_hit)) || (r_state == DONE);
  assign rd_data           = (ack && !r_is_wr && !r_fault) ? w_arr_rdata : '0;
  assign miss              = (w_lookup_ok && !w_hit) || (r_state == WB) || (r_state == FILL);
  assign d_cache_seg_fault = r_seg_fault;
  assign mem_req           = (r_state == WB) || (r_state == FILL);
  assign mem_we            = (r_state == WB);
  assign mem_wdata         = (r_state == WB) ? w_arr_rdata : '0;

  always_comb begin
    mem_addr = '0;
    if (r_state == WB)   mem_addr = {r_tag[w_idx], w_idx, r_beat, 2'b00};
    if (r_state == FILL) mem_addr = {w_req_tag, w_idx, r_beat, 2'b00};
  end

endmodule

// File: tb/tb_d_cache_dm.sv
// Directed self-checking bench for d_cache_dm with a behavioural word memory
// that can insert random per-beat stalls and logs every completed beat.
module tb_d_cache_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] addr_in = '0;
  logic [31:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        seg_clr = 1'b0;
  logic        ready, ack, miss, d_cache_seg_fault;
  logic [31:0] rd_data;
  logic        mem_req, mem_we;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [256];
  logic [19:0] beat_addr [$];
  logic        beat_we [$];
  logic [31:0] beat_wdata [$];
  int          max_stall = 0;
  int          stall_left = 0;
  int          stab_viol = 0;
  logic        hold_valid = 1'b0;
  logic [19:0] hold_addr;
  logic        hold_we;
  logic [31:0] hold_wdata;

  always #5 clk = ~clk;

  d_cache_dm dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .addr_in          (addr_in),
    .wr_data          (wr_data),
    .wr_en            (wr_en),
    .rd_en            (rd_en),
    .seg_clr          (seg_clr),
    .ready            (ready),
    .ack              (ack),
    .rd_data          (rd_data),
    .miss             (miss),
    .d_cache_seg_fault(d_cache_seg_fault),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack)
  );

  // Memory model: acks each beat after a random stall, tracks beat stability
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      hold_valid = 1'b0;
      stall_left = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      hold_valid = 1'b0;
    end else if (mem_req) begin
      if (hold_valid && (mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata))
        stab_viol++;
      hold_valid = 1'b1;
      hold_addr = mem_addr;
      hold_we = mem_we;
      hold_wdata = mem_wdata;
      if (stall_left > 0) begin
        stall_left--;
      end else begin
        beat_addr.push_back(mem_addr);
        beat_we.push_back(mem_we);
        beat_wdata.push_back(mem_wdata);
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        else        mem_rdata = mem[mem_addr[9:2]];
        mem_ack = 1'b1;
        stall_left = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      end
    end else begin
      if (hold_valid) stab_viol++;
      hold_valid = 1'b0;
    end
  end

  task automatic clear_log();
    beat_addr.delete();
    beat_we.delete();
    beat_wdata.delete();
  endtask

  task automatic do_req(input bit wr, input logic [19:0] a, input logic [31:0] d,
                        output logic [31:0] rdat, output int lat,
                        output logic miss_t1, output logic seg_t1);
    @(negedge clk);
    addr_in = a;
    wr_data = d;
    wr_en = wr;
    rd_en = !wr;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr_in = '0;
    miss_t1 = miss;
    seg_t1 = d_cache_seg_fault;
    lat = 0;
    rdat = 'x;
    for (int n = 1; n <= 300; n++) begin
      if (ack) begin
        lat = n;
        rdat = rd_data;
        break;
      end
      @(negedge clk);
    end
    $display("req %s addr=%h lat=%0d rd_data=%h beats=%0d", wr ? "ST" : "LD", a, lat, rdat,
             beat_addr.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, miss, mem_req, mem_we, d_cache_seg_fault} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {ack, miss, mem_req, mem_we, d_cache_seg_fault});
    end
    checks++;
    if ({rd_data, mem_addr, mem_wdata} !== 84'h0) begin
      failures++;
      $display("FAIL reset_data: got rd=%h addr=%h wdata=%h expected all 0", rd_data, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_cold_read();
    logic [31:0] r; int lat; logic m1, s1;
    clear_log();
    do_req(1'b0, 20'h10204, 32'h0, r, lat, m1, s1);
    checks++;
    if (m1 !== 1'b1) begin failures++; $display("FAIL cold_miss_t1: got %b expected 1", m1); end
    checks++;
    if (beat_addr.size() != 8) begin failures++; $display("FAIL cold_beats: got %0d expected 8", beat_addr.size()); end
    for (int i = 0; i < 8 && i < beat_addr.size(); i++) begin
      checks++;
      if (beat_addr[i] !== 20'h10200 + 20'(4*i) || beat_we[i] !== 1'b0) begin
        failures++;
        $display("FAIL cold_beat%0d: got addr=%h we=%b expected addr=%h we=0", i, beat_addr[i], beat_we[i], 20'h10200 + 20'(4*i));
      end
    end
    checks++;
    if (r !== 32'hA1) begin failures++; $display("FAIL cold_data: got %h expected 000000a1", r); end
    checks++;
    if (miss !== 1'b0) begin failures++; $display("FAIL cold_miss_ack: got %b expected 0", miss); end
    clear_log();
    do_req(1'b0, 20'h10204, 32'h0, r, lat, m1, s1);
    checks++;
    if (lat !== 1 || r !== 32'hA1 || beat_addr.size() != 0 || m1 !== 1'b0) begin
      failures++;
      $display("FAIL reread_hit: got lat=%0d data=%h beats=%0d miss=%b expected lat=1 data=a1 beats=0 miss=0", lat, r, beat_addr.size(), m1);
    end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL ready_t1: got %b expected 0", ready); end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL ready_t2: got %b expected 1", ready); end
  endtask

  task automatic test_store_hit();
    logic [31:0] r; int lat; logic m1, s1;
    clear_log();
    do_req(1'b1, 20'h10208, 32'hDEADBEEF, r, lat, m1, s1);
    checks++;
    if (lat !== 1 || beat_addr.size() != 0) begin
      failures++;
      $display("FAIL store_hit: got lat=%0d beats=%0d expected lat=1 beats=0", lat, beat_addr.size());
    end
    do_req(1'b0, 20'h10208, 32'h0, r, lat, m1, s1);
    checks++;
    if (lat !== 1 || r !== 32'hDEADBEEF || beat_addr.size() != 0) begin
      failures++;
      $display("FAIL store_readback: got lat=%0d data=%h beats=%0d expected lat=1 data=deadbeef beats=0", lat, r, beat_addr.size());
    end
  endtask

  task automatic test_dirty_evict(input logic [31:0] w1, input string tag);
    logic [31:0] r; int lat; logic m1, s1;
    logic [31:0] exp;
    clear_log();
    do_req(1'b0, 20'h10300, 32'h0, r, lat, m1, s1);
    checks++;
    if (beat_addr.size() != 16) begin failures++; $display("FAIL %s_beats: got %0d expected 16", tag, beat_addr.size()); end
    for (int i = 0; i < 16 && i < beat_addr.size(); i++) begin
      if (i < 8) exp = (i == 2) ? 32'hDEADBEEF : (i == 1) ? w1 : 32'hA0 + 32'(i);
      else       exp = 32'h0;
      checks++;
      if (beat_addr[i] !== ((i < 8) ? 20'h10200 + 20'(4*i) : 20'h10300 + 20'(4*(i-8))) ||
          beat_we[i] !== (i < 8) || (i < 8 && beat_wdata[i] !== exp)) begin
        failures++;
        $display("FAIL %s_beat%0d: got addr=%h we=%b wdata=%h expected wdata=%h", tag, i, beat_addr[i], beat_we[i], beat_wdata[i], exp);
      end
    end
    checks++;
    if (r !== 32'hB0) begin failures++; $display("FAIL %s_data: got %h expected 000000b0", tag, r); end
    checks++;
    if (mem[8'h82] !== 32'hDEADBEEF) begin failures++; $display("FAIL %s_mem: got %h expected deadbeef", tag, mem[8'h82]); end
  endtask

  task automatic test_store_miss();
    logic [31:0] r; int lat; logic m1, s1;
    clear_log();
    do_req(1'b1, 20'h10224, 32'h12345678, r, lat, m1, s1);
    checks++;
    if (m1 !== 1'b1 || beat_addr.size() != 8 || beat_we[0] !== 1'b0 || beat_addr[0] !== 20'h10220) begin
      failures++;
      $display("FAIL store_miss: got miss=%b beats=%0d first=%h expected miss=1 beats=8 first=10220 read", m1, beat_addr.size(), beat_addr[0]);
    end
    clear_log();
    do_req(1'b0, 20'h10224, 32'h0, r, lat, m1, s1);
    checks++;
    if (lat !== 1 || r !== 32'h12345678) begin failures++; $display("FAIL store_miss_merge: got lat=%0d data=%h expected lat=1 data=12345678", lat, r); end
    do_req(1'b0, 20'h10220, 32'h0, r, lat, m1, s1);
    checks++;
    if (lat !== 1 || r !== 32'hC0000088 || beat_addr.size() != 0) begin
      failures++;
      $display("FAIL store_miss_neighbour: got lat=%0d data=%h beats=%0d expected lat=1 data=c0000088 beats=0", lat, r, beat_addr.size());
    end
  endtask

  task automatic test_fault();
    logic [31:0] r; int lat; logic m1, s1;
    clear_log();
    do_req(1'b0, 20'h10400, 32'h0, r, lat, m1, s1);
    checks++;
    if (lat !== 1 || r !== 32'h0 || s1 !== 1'b1 || beat_addr.size() != 0) begin
      failures++;
      $display("FAIL fault_high: got lat=%0d data=%h seg=%b beats=%0d expected lat=1 data=0 seg=1 beats=0", lat, r, s1, beat_addr.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (d_cache_seg_fault !== 1'b1) begin failures++; $display("FAIL fault_sticky: got %b expected 1", d_cache_seg_fault); end
    seg_clr = 1'b1;
    @(negedge clk);
    seg_clr = 1'b0;
    checks++;
    if (d_cache_seg_fault !== 1'b0) begin failures++; $display("FAIL fault_clear: got %b expected 0", d_cache_seg_fault); end
    do_req(1'b0, 20'h10202, 32'h0, r, lat, m1, s1);
    checks++;
    if (lat !== 1 || r !== 32'h0 || s1 !== 1'b1) begin
      failures++;
      $display("FAIL fault_misaligned: got lat=%0d data=%h seg=%b expected lat=1 data=0 seg=1", lat, r, s1);
    end
    seg_clr = 1'b1;
    do_req(1'b0, 20'h101FC, 32'h0, r, lat, m1, s1);
    seg_clr = 1'b0;
    checks++;
    if (s1 !== 1'b1 || lat !== 1) begin failures++; $display("FAIL fault_set_wins: got seg=%b lat=%0d expected seg=1 lat=1", s1, lat); end
    @(negedge clk);
    checks++;
    if (d_cache_seg_fault !== 1'b1) begin failures++; $display("FAIL fault_set_hold: got %b expected 1", d_cache_seg_fault); end
    seg_clr = 1'b1;
    @(negedge clk);
    seg_clr = 1'b0;
    do_req(1'b0, 20'h103FC, 32'h0, r, lat, m1, s1);
    checks++;
    if (s1 !== 1'b0 || m1 !== 1'b1 || r !== 32'hC00000FF) begin
      failures++;
      $display("FAIL seg_hi_legal: got seg=%b miss=%b data=%h expected seg=0 miss=1 data=c00000ff", s1, m1, r);
    end
  endtask

  task automatic test_stalls();
    logic [31:0] r; int lat; logic m1, s1;
    max_stall = 5;
    stab_viol = 0;
    clear_log();
    do_req(1'b0, 20'h10200, 32'h0, r, lat, m1, s1);
    checks++;
    if (r !== 32'hA0 || beat_addr.size() != 8 || beat_we[0] !== 1'b0 || beat_addr[7] !== 20'h1021C) begin
      failures++;
      $display("FAIL stall_fill: got data=%h beats=%0d last=%h expected data=a0 beats=8 last=1021c", r, beat_addr.size(), beat_addr[7]);
    end
    do_req(1'b0, 20'h10208, 32'h0, r, lat, m1, s1);
    checks++;
    if (lat !== 1 || r !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_hit: got lat=%0d data=%h expected lat=1 data=deadbeef", lat, r); end
    do_req(1'b1, 20'h10204, 32'h000055AA, r, lat, m1, s1);
    test_dirty_evict(32'h000055AA, "stall_evict");
    checks++;
    if (stab_viol != 0) begin failures++; $display("FAIL stall_stable: got %0d violations expected 0", stab_viol); end
    max_stall = 0;
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] r; int lat; logic m1, s1;
    bit seen;
    clear_log();
    @(negedge clk);
    addr_in = 20'h10240;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (beat_addr.size() >= 3) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen || miss !== 1'b1) begin failures++; $display("FAIL rst_fill_reach: got beats=%0d miss=%b expected >=3 beats miss=1", beat_addr.size(), miss); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, miss, mem_req, mem_we, d_cache_seg_fault} !== 5'b0 || {rd_data, mem_addr, mem_wdata} !== 84'h0) begin
      failures++;
      $display("FAIL rst_immediate: got ctrl=%b addr=%h expected all 0", {ack, miss, mem_req, mem_we, d_cache_seg_fault}, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    do_req(1'b0, 20'h10240, 32'h0, r, lat, m1, s1);
    checks++;
    if (m1 !== 1'b1 || beat_addr.size() != 8 || r !== 32'hC0000090) begin
      failures++;
      $display("FAIL rst_remiss: got miss=%b beats=%0d data=%h expected miss=1 beats=8 data=c0000090", m1, beat_addr.size(), r);
    end
    clear_log();
    do_req(1'b0, 20'h10300, 32'h0, r, lat, m1, s1);
    checks++;
    if (m1 !== 1'b1 || beat_addr.size() != 8 || r !== 32'hB0) begin
      failures++;
      $display("FAIL rst_invalidated: got miss=%b beats=%0d data=%h expected miss=1 beats=8 data=b0", m1, beat_addr.size(), r);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0000000 | 32'(i);
    for (int i = 0; i < 8; i++) begin
      mem[8'h80 + i] = 32'hA0 + 32'(i);
      mem[8'hC0 + i] = 32'hB0 + 32'(i);
    end
    test_reset();
    test_cold_read();
    test_store_hit();
    test_dirty_evict(32'hA1, "evict");
    test_store_miss();
    test_fault();
    test_stalls();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
